// File: rtl/mips_execute_stage.sv
// mips_execute_stage: EX stage of the 5-stage pipelined MIPS core.
//   Holds the ID/EX pipeline register. FlushE turns the register into a bubble.
//   The forwarding muxes pick the ALU operands from the ID/EX data, the WB result
//   or the MEM-stage ALU result. The ALU then computes ALUOutE.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   FlushE                synchronous clear of the ID/EX register
//   *D                    decode-stage control, data and register fields
//   *E (registered)       ID/EX register contents presented to later stages and the hazard unit
//   ResultW, ALUOutM      forwarding sources (combinational)
//   ForwardAE, ForwardBE  forwarding selects (combinational)
//   WriteRegE, WriteDataE, ALUOutE  combinational EX results
module mips_execute_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        FlushE,
    input  logic        RegWriteD,
    input  logic        MemtoRegD,
    input  logic        MemWriteD,
    input  logic [3:0]  ALUControlD,
    input  logic        ALUSrcD,
    input  logic        RegDstD,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RdD,
    input  logic [31:0] SignImmD,
    input  logic [4:0]  shamtD,
    output logic        RegWriteE,
    output logic        MemtoRegE,
    output logic        MemWriteE,
    output logic        RegDstE,
    output logic [3:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [4:0]  RsE,
    output logic [4:0]  RtE,
    output logic [4:0]  RdE,
    output logic [31:0] SignImmE,
    input  logic [31:0] ResultW,
    input  logic [31:0] ALUOutM,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    output logic [4:0]  WriteRegE,
    output logic [31:0] WriteDataE,
    output logic [31:0] ALUOutE
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned ALU_W  = 4;

    // ALU operation codes
    localparam logic [ALU_W-1:0] OP_AND = 4'd0;
    localparam logic [ALU_W-1:0] OP_OR  = 4'd1;
    localparam logic [ALU_W-1:0] OP_ADD = 4'd2;
    localparam logic [ALU_W-1:0] OP_SLL = 4'd3;
    localparam logic [ALU_W-1:0] OP_SRL = 4'd4;
    localparam logic [ALU_W-1:0] OP_SRA = 4'd5;
    localparam logic [ALU_W-1:0] OP_SUB = 4'd6;
    localparam logic [ALU_W-1:0] OP_SLT = 4'd7;
    localparam logic [ALU_W-1:0] OP_NOR = 4'd12;
    localparam logic [ALU_W-1:0] OP_XOR = 4'd13;

    // Forwarding select encodings
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // ID/EX register payload
    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic [ALU_W-1:0]  alu_control;
        logic              alu_src;
        logic              reg_dst;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] sign_imm;
        logic [REG_W-1:0]  shamt;
    } idex_t;

    idex_t idex_d;
    idex_t idex_q;

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] alu_out;

    // Next ID/EX contents: a flush loads an all-zero bubble
    always_comb begin
        idex_d             = '0;
        if (!FlushE) begin
            idex_d.reg_write   = RegWriteD;
            idex_d.mem_to_reg  = MemtoRegD;
            idex_d.mem_write   = MemWriteD;
            idex_d.alu_control = ALUControlD;
            idex_d.alu_src     = ALUSrcD;
            idex_d.reg_dst     = RegDstD;
            idex_d.rd1         = RD1D;
            idex_d.rd2         = RD2D;
            idex_d.rs          = RsD;
            idex_d.rt          = RtD;
            idex_d.rd          = RdD;
            idex_d.sign_imm    = SignImmD;
            idex_d.shamt       = shamtD;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.reg_write;
    assign MemtoRegE   = idex_q.mem_to_reg;
    assign MemWriteE   = idex_q.mem_write;
    assign RegDstE     = idex_q.reg_dst;
    assign ALUControlE = idex_q.alu_control;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign RsE         = idex_q.rs;
    assign RtE         = idex_q.rt;
    assign RdE         = idex_q.rd;
    assign SignImmE    = idex_q.sign_imm;

    // Destination register: Rd for R-type, Rt for I-type
    assign WriteRegE = idex_q.reg_dst ? idex_q.rd : idex_q.rt;

    // Forwarding mux for SrcA; select 11 yields zero
    always_comb begin
        src_a = '0;
        unique case (ForwardAE)
            FWD_REG: src_a = idex_q.rd1;
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUOutM;
            default: src_a = '0;
        endcase
    end

    // Forwarding mux for the Rt operand; it also serves as store data
    always_comb begin
        write_data = '0;
        unique case (ForwardBE)
            FWD_REG: write_data = idex_q.rd2;
            FWD_WB:  write_data = ResultW;
            FWD_MEM: write_data = ALUOutM;
            default: write_data = '0;
        endcase
    end

    assign WriteDataE = write_data;
    assign src_b      = idex_q.alu_src ? idex_q.sign_imm : write_data;

    // ALU; shifts use the registered shamt, undefined codes give zero
    always_comb begin
        alu_out = '0;
        unique case (idex_q.alu_control)
            OP_AND:  alu_out = src_a & src_b;
            OP_OR:   alu_out = src_a | src_b;
            OP_ADD:  alu_out = src_a + src_b;
            OP_SUB:  alu_out = src_a - src_b;
            OP_SLT:  alu_out = DATA_W'(($signed(src_a) < $signed(src_b)) ? 1 : 0);
            OP_SLL:  alu_out = src_b << idex_q.shamt;
            OP_SRL:  alu_out = src_b >> idex_q.shamt;
            OP_SRA:  alu_out = DATA_W'($signed(src_b) >>> idex_q.shamt);
            OP_NOR:  alu_out = ~(src_a | src_b);
            OP_XOR:  alu_out = src_a ^ src_b;
            default: alu_out = '0;
        endcase
    end

    assign ALUOutE = alu_out;

endmodule

// File: tb/tb_mips_execute_stage.sv
// Testbench for mips_execute_stage. It applies directed vectors from a table,
// runs hand-written flush and reset sequences, then applies random traffic
// against a reference model.
module tb_mips_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        FlushE;
    logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
    logic [3:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, SignImmD;
    logic [4:0]  RsD, RtD, RdD, shamtD;
    logic        RegWriteE, MemtoRegE, MemWriteE, RegDstE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, SignImmE;
    logic [4:0]  RsE, RtE, RdE;
    logic [31:0] ResultW, ALUOutM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [4:0]  WriteRegE;
    logic [31:0] WriteDataE, ALUOutE;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mips_execute_stage dut (
        .clk(clk), .rst_n(rst_n), .FlushE(FlushE),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
        .RD1D(RD1D), .RD2D(RD2D), .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .SignImmD(SignImmD), .shamtD(shamtD),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .RegDstE(RegDstE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
        .RsE(RsE), .RtE(RtE), .RdE(RdE), .SignImmE(SignImmE),
        .ResultW(ResultW), .ALUOutM(ALUOutM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .WriteRegE(WriteRegE), .WriteDataE(WriteDataE), .ALUOutE(ALUOutE)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // OR of every registered output, used to check that all of them are zero
    function automatic logic any_e();
        return |{RegWriteE, MemtoRegE, MemWriteE, RegDstE, ALUControlE,
                 RD1E, RD2E, RsE, RtE, RdE, SignImmE, WriteRegE};
    endfunction

    // Directed vector: decode inputs, mid-cycle forwarding inputs, expected results
    typedef struct {
        logic [3:0]  ctrl;
        logic        src;
        logic        dst;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rt, rd, sh;
        logic [1:0]  fa, fb;
        logic [31:0] rw, am;
        logic [31:0] e_alu, e_wd;
        logic [4:0]  e_wr;
    } vec_t;

    function automatic vec_t mk(
        input logic [3:0] ctrl, input logic src, input logic dst,
        input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
        input logic [1:0] fa, input logic [1:0] fb,
        input logic [31:0] rw, input logic [31:0] am,
        input logic [31:0] e_alu, input logic [31:0] e_wd, input logic [4:0] e_wr);
        vec_t v;
        v.ctrl = ctrl; v.src = src; v.dst = dst; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
        v.rt = rt; v.rd = rd; v.sh = sh; v.fa = fa; v.fb = fb; v.rw = rw; v.am = am;
        v.e_alu = e_alu; v.e_wd = e_wd; v.e_wr = e_wr;
        return v;
    endfunction

    // Reference model state: the decode bundle most recently accepted by the pipeline
    typedef struct packed {
        logic        rw, m2r, mw;
        logic [3:0]  ctrl;
        logic        src, dst;
        logic [31:0] rd1, rd2;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm;
        logic [4:0]  sh;
    } model_t;

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_val,
                                         input logic [31:0] wb, input logic [31:0] mem);
        case (sel)
            2'd0:    return reg_val;
            2'd1:    return wb;
            2'd2:    return mem;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        longint unsigned p2;
        longint sa, sb;
        p2 = 64'd1 << sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return 32'((longint'(a) + longint'(b)) % (64'd1 << 32));
            4'd6:  return 32'((longint'(a) + (64'd1 << 32) - longint'(b)) % (64'd1 << 32));
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd3:  return 32'((longint'(b) * p2) % (64'd1 << 32));
            4'd4:  return 32'(longint'(b) / p2);
            // Arithmetic shift is floor division of the signed value
            4'd5:  return 32'((sb >= 0) ? sb / longint'(p2) : -((-sb + longint'(p2) - 1) / longint'(p2)));
            4'd12: return ~(a | b);
            4'd13: return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic zero_inputs();
        FlushE = 0; RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; ALUSrcD = 0; RegDstD = 0;
        ALUControlD = 0; RD1D = 0; RD2D = 0; SignImmD = 0; RsD = 0; RtD = 0; RdD = 0; shamtD = 0;
        ResultW = 0; ALUOutM = 0; ForwardAE = 0; ForwardBE = 0;
    endtask

    vec_t   vt[$];
    model_t m, nd;
    logic   fl;

    initial begin
        zero_inputs();
        rst_n = 0;
        #3;
        check("reset_regs_zero", 128'(any_e()), 128'd0);
        check("reset_aluout", 128'(ALUOutE), 128'd0);
        check("reset_wdata", 128'(WriteDataE), 128'd0);
        @(negedge clk);
        rst_n = 1;

        //      ctrl src dst rd1          rd2          imm          rt  rd  sh fa fb rw           am           alu          wd           wr
        vt.push_back(mk(4'd0,  0, 0, 32'd3,        32'd3,        32'd0,        12, 16, 0, 0, 0, 32'd0,        32'd0,        32'd3,        32'd3,        12));
        vt.push_back(mk(4'd1,  0, 1, 32'd3,        32'd3,        32'd0,        12, 16, 0, 1, 0, 32'd7,        32'd0,        32'd7,        32'd3,        16));
        vt.push_back(mk(4'd2,  0, 0, 32'd42,       32'd3,        32'd0,        12, 16, 0, 0, 1, 32'd32,       32'd22,       32'd74,       32'd32,       12));
        vt.push_back(mk(4'd6,  0, 1, 32'd3,        32'd3,        32'd0,        1,  31, 0, 2, 1, 32'd32,       32'd22,       32'hFFFFFFF6, 32'd32,       31));
        vt.push_back(mk(4'd7,  1, 0, 32'd3,        32'd5,        32'd0,        7,  0,  0, 2, 0, 32'd0,        32'd22,       32'd0,        32'd5,        7));
        vt.push_back(mk(4'd7,  1, 0, 32'd3,        32'd5,        32'hFFFFFFFF, 7,  0,  0, 2, 0, 32'd0,        32'd22,       32'd0,        32'd5,        7));
        vt.push_back(mk(4'd7,  1, 0, 32'd3,        32'd5,        32'd0,        7,  0,  0, 2, 0, 32'd0,        32'hFFFFFFFF, 32'd1,        32'd5,        7));
        vt.push_back(mk(4'd3,  0, 0, 32'd0,        32'h80000000, 32'd0,        2,  0,  4, 0, 0, 32'd0,        32'd0,        32'd0,        32'h80000000, 2));
        vt.push_back(mk(4'd4,  0, 0, 32'd0,        32'h80000000, 32'd0,        2,  0,  4, 0, 0, 32'd0,        32'd0,        32'h08000000, 32'h80000000, 2));
        vt.push_back(mk(4'd5,  0, 0, 32'd0,        32'h80000000, 32'd0,        2,  0,  4, 0, 0, 32'd0,        32'd0,        32'hF8000000, 32'h80000000, 2));
        vt.push_back(mk(4'd12, 0, 0, 32'h0F0F0000, 32'h00FF00FF, 32'd0,        0,  0,  0, 0, 0, 32'd0,        32'd0,        32'hF000FF00, 32'h00FF00FF, 0));
        vt.push_back(mk(4'd13, 0, 0, 32'h0F0F0000, 32'h00FF00FF, 32'd0,        0,  0,  0, 0, 0, 32'd0,        32'd0,        32'h0FF000FF, 32'h00FF00FF, 0));
        vt.push_back(mk(4'd8,  0, 0, 32'h12345678, 32'h11111111, 32'd0,        0,  0,  0, 0, 0, 32'd0,        32'd0,        32'd0,        32'h11111111, 0));
        vt.push_back(mk(4'd2,  0, 0, 32'h12345678, 32'h11111111, 32'd0,        0,  0,  0, 3, 3, 32'd9,        32'd9,        32'd0,        32'd0,        0));
        vt.push_back(mk(4'd2,  0, 0, 32'd3,        32'd3,        32'd0,        0,  0,  0, 0, 2, 32'd32,       32'd22,       32'd25,       32'd22,       0));

        foreach (vt[i]) begin
            ALUControlD = vt[i].ctrl; ALUSrcD = vt[i].src; RegDstD = vt[i].dst;
            RD1D = vt[i].rd1; RD2D = vt[i].rd2; SignImmD = vt[i].imm;
            RtD = vt[i].rt; RdD = vt[i].rd; shamtD = vt[i].sh; FlushE = 0;
            @(posedge clk); #1;
            ForwardAE = vt[i].fa; ForwardBE = vt[i].fb; ResultW = vt[i].rw; ALUOutM = vt[i].am;
            #1;
            check($sformatf("vec%0d_alu", i), 128'(ALUOutE), 128'(vt[i].e_alu));
            check($sformatf("vec%0d_wdata", i), 128'(WriteDataE), 128'(vt[i].e_wd));
            check($sformatf("vec%0d_wreg", i), 128'(WriteRegE), 128'(vt[i].e_wr));
        end

        // Flush: load a non-zero bundle, then flush it into a bubble
        zero_inputs();
        RegWriteD = 1; MemtoRegD = 1; MemWriteD = 1; RegDstD = 1; ALUControlD = 4'd2;
        RD1D = 32'hAA; RD2D = 32'hBB; RsD = 3; RtD = 4; RdD = 5; SignImmD = 32'hCC; shamtD = 7;
        @(posedge clk); #1;
        check("preflush_loaded", 128'(any_e()), 128'd1);
        FlushE = 1;
        @(posedge clk); #1;
        check("flush_regs_zero", 128'(any_e()), 128'd0);
        check("flush_wreg_zero", 128'(WriteRegE), 128'd0);
        check("flush_alu_zero", 128'(ALUOutE), 128'd0);

        // Reset asserted mid-cycle clears the register without a clock edge
        FlushE = 0;
        @(posedge clk); #1;
        check("prereset_loaded", 128'(RD1E), 128'hAA);
        #2;
        rst_n = 0;
        #1;
        check("async_reset_regs", 128'(any_e()), 128'd0);
        check("async_reset_alu", 128'(ALUOutE), 128'd0);
        @(negedge clk);
        rst_n = 1;
        zero_inputs();

        // Random traffic against the model
        @(posedge clk); #1;
        m = '0;
        for (int it = 0; it < 300; it++) begin
            nd.rw   = 1'($urandom); nd.m2r = 1'($urandom); nd.mw = 1'($urandom);
            nd.ctrl = 4'($urandom); nd.src = 1'($urandom); nd.dst = 1'($urandom);
            nd.rd1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            nd.rd2  = $urandom;
            nd.rs   = 5'($urandom); nd.rt = 5'($urandom); nd.rd = 5'($urandom);
            nd.imm  = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
            nd.sh   = 5'($urandom);
            fl      = ($urandom_range(0, 7) == 0);
            RegWriteD = nd.rw; MemtoRegD = nd.m2r; MemWriteD = nd.mw; ALUControlD = nd.ctrl;
            ALUSrcD = nd.src; RegDstD = nd.dst; RD1D = nd.rd1; RD2D = nd.rd2;
            RsD = nd.rs; RtD = nd.rt; RdD = nd.rd; SignImmD = nd.imm; shamtD = nd.sh; FlushE = fl;
            @(posedge clk);
            m = fl ? '0 : nd;
            #1;
            ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            ResultW = $urandom; ALUOutM = $urandom;
            #1;
            begin
                logic [31:0] a, wd, b;
                a  = pick(ForwardAE, m.rd1, ResultW, ALUOutM);
                wd = pick(ForwardBE, m.rd2, ResultW, ALUOutM);
                b  = m.src ? m.imm : wd;
                check($sformatf("rnd%0d_alu op%0d", it, m.ctrl), 128'(ALUOutE), 128'(ref_alu(m.ctrl, a, b, m.sh)));
                check($sformatf("rnd%0d_wdata", it), 128'(WriteDataE), 128'(wd));
                check($sformatf("rnd%0d_wreg", it), 128'(WriteRegE), 128'(m.dst ? m.rd : m.rt));
                check($sformatf("rnd%0d_regs", it),
                      128'({RegWriteE, MemtoRegE, MemWriteE, RegDstE, ALUControlE,
                            RD1E, RD2E, RsE, RtE, RdE, SignImmE}),
                      128'({m.rw, m.m2r, m.mw, m.dst, m.ctrl, m.rd1, m.rd2, m.rs, m.rt, m.rd, m.imm}));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
